// File: rtl/cache_arbiter_pkg.sv
// Shared types for the I/D-cache to memory-port arbiter.
package cache_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_SERVE_I = 2'd1,
    ARB_SERVE_D = 2'd2,
    ARB_DONE    = 2'd3
  } arb_state_t;

  typedef logic [255:0] cacheline_t;

  // Bits needed to hold a saturating count from 0 up to and including limit.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/cache_arbiter_arb_select.sv
// Combinational priority pick: D-cache wins by default, except when the
// I-cache has already been passed over STARVE_LIMIT times in a row.
module cache_arbiter_arb_select #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic             i_pend,
  input  logic             i_d_pend,
  input  logic [CNT_W-1:0] i_starve_cnt,
  output logic             o_grant_i,
  output logic             o_grant_d
);

  logic w_force_i;

  // I is forced only when it is waiting and its starvation allowance is used up
  always_comb begin
    w_force_i = i_pend && (i_starve_cnt == CNT_W'(STARVE_LIMIT));
    o_grant_d = i_d_pend && !w_force_i;
    o_grant_i = i_pend && !o_grant_d;
  end

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates the single cacheline memory port between the I-cache and
// D-cache miss paths. One 256-bit transaction at a time; the granted request
// is latched and presented unchanged until the adaptor answers.
module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter int unsigned LINE_W       = 256,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic              busy,
  output logic              grant_d
);

  localparam int unsigned CNT_W = cnt_width(STARVE_LIMIT);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic [CNT_W-1:0]  r_starve_cnt;
  logic              r_last_d;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic [LINE_W-1:0] r_i_rdata;
  logic [LINE_W-1:0] r_d_rdata;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_i_resp;
  logic              r_d_resp;

  logic w_i_pend;
  logic w_d_pend;
  logic w_grant_i;
  logic w_grant_d;
  logic w_take_i;
  logic w_take_d;
  logic w_done_i;
  logic w_done_d;

  assign w_i_pend = i_read;
  assign w_d_pend = d_read | d_write;

  cache_arbiter_arb_select #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_arb_select (
    .i_pend       (w_i_pend),
    .i_d_pend     (w_d_pend),
    .i_starve_cnt (r_starve_cnt),
    .o_grant_i    (w_grant_i),
    .o_grant_d    (w_grant_d)
  );

  // Grants are only taken in IDLE; completions only count while serving.
  assign w_take_d = (r_state == ARB_IDLE) && w_grant_d;
  assign w_take_i = (r_state == ARB_IDLE) && w_grant_i;
  assign w_done_i = (r_state == ARB_SERVE_I) && mem_resp;
  assign w_done_d = (r_state == ARB_SERVE_D) && mem_resp;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: DONE lasts one cycle so the cache can drop its request
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE: begin
        if (w_grant_d) begin
          w_state_nxt = ARB_SERVE_D;
        end else if (w_grant_i) begin
          w_state_nxt = ARB_SERVE_I;
        end
      end
      ARB_SERVE_I,
      ARB_SERVE_D: begin
        if (mem_resp) begin
          w_state_nxt = ARB_DONE;
        end
      end
      ARB_DONE: w_state_nxt = ARB_IDLE;
      default:  w_state_nxt = ARB_IDLE;
    endcase
  end

  // Output logic: memory side and status come straight from registers
  always_comb begin
    busy      = (r_state != ARB_IDLE);
    grant_d   = r_last_d;
    mem_read  = r_mem_read;
    mem_write = r_mem_write;
    mem_addr  = r_addr;
    mem_wdata = r_wdata;
    i_rdata   = r_i_rdata;
    d_rdata   = r_d_rdata;
    i_resp    = r_i_resp;
    d_resp    = r_d_resp;
  end

  // Latch the winner's request at grant; drop the memory strobe after the response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else if (w_take_d) begin
      r_addr      <= d_addr;
      r_wdata     <= d_wdata;
      // d_write wins if both are (illegally) raised together
      r_mem_write <= d_write;
      r_mem_read  <= !d_write;
    end else if (w_take_i) begin
      r_addr      <= i_addr;
      r_mem_read  <= 1'b1;
      r_mem_write <= 1'b0;
    end else if (w_done_i || w_done_d) begin
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end
  end

  // Return the line to the granted side only, with a one-cycle response pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i_rdata <= '0;
      r_d_rdata <= '0;
      r_i_resp  <= 1'b0;
      r_d_resp  <= 1'b0;
    end else begin
      r_i_resp <= w_done_i;
      r_d_resp <= w_done_d;
      if (w_done_i) begin
        r_i_rdata <= mem_rdata;
      end
      if (w_done_d) begin
        r_d_rdata <= mem_rdata;
      end
    end
  end

  // Count D grants that passed over a waiting I; any other grant clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (w_take_d) begin
      if (!w_i_pend) begin
        r_starve_cnt <= '0;
      end else if (r_starve_cnt != CNT_W'(STARVE_LIMIT)) begin
        r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end
    end else if (w_take_i) begin
      r_starve_cnt <= '0;
    end
  end

  // Remember which side was granted last; held through IDLE for the stall unit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_d <= 1'b0;
    end else if (w_take_d) begin
      r_last_d <= 1'b1;
    end else if (w_take_i) begin
      r_last_d <= 1'b0;
    end
  end

  // Protocol checks on the adaptor and the D-cache request encoding
  a_resp_in_flight : assert property (@(posedge clk) disable iff (!rst_n)
    !(mem_resp && ((r_state == ARB_IDLE) || (r_state == ARB_DONE))))
    else $warning("cache_arbiter: mem_resp with no transaction in flight");

  a_d_one_hot : assert property (@(posedge clk) disable iff (!rst_n)
    !(d_read && d_write))
    else $warning("cache_arbiter: d_read and d_write asserted together");

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed plus randomized bench for cache_arbiter. A small reference model
// decides which side should win each arbitration from the priority and
// starvation rules; an inline adaptor model answers memory requests.
module tb_cache_arbiter;
  import cache_arbiter_pkg::*;

  localparam int LINE_W       = 256;
  localparam int ADDR_W       = 32;
  localparam int STARVE_LIMIT = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;
  logic              busy;
  logic              grant_d;

  always #5 clk = ~clk;

  cache_arbiter #(
    .LINE_W       (LINE_W),
    .ADDR_W       (ADDR_W),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_read    (i_read),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_resp    (i_resp),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_resp    (d_resp),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_resp  (mem_resp),
    .busy      (busy),
    .grant_d   (grant_d)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int         streak = 0;        // D grants in a row while I was waiting
  cacheline_t exp_i_rdata = '0;
  cacheline_t exp_d_rdata = '0;
  logic       exp_grant_d = 1'b0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic cacheline_t rand_line();
    cacheline_t l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [31:0] rand_addr();
    return $urandom & 32'hFFFF_FFC0;
  endfunction

  // D wins unless I has been passed over STARVE_LIMIT times already
  function automatic bit model_pick_d(input bit ip, input bit dp);
    return dp && !(ip && (streak >= STARVE_LIMIT));
  endfunction

  task automatic model_grant(input bit took_d, input bit ip);
    if (took_d && ip) streak = (streak < STARVE_LIMIT) ? streak + 1 : streak;
    else              streak = 0;
  endtask

  // Act as the adaptor for one transaction and check both cache interfaces
  task automatic serve(input bit exp_d, input bit exp_wr, input logic [31:0] exp_addr,
                       input cacheline_t exp_wd, input int lat, input cacheline_t rd,
                       input bit toggle, input string tag);
    int waited = 0;
    while (!(mem_read || mem_write) && waited < 40) begin
      @(negedge clk);
      waited++;
      chk({tag, ".early_resp"}, {i_resp, d_resp}, 2'b00);
    end
    chk({tag, ".latency"}, 256'(waited), 256'(1));
    chk({tag, ".mem_read"}, mem_read, !exp_wr);
    chk({tag, ".mem_write"}, mem_write, exp_wr);
    chk({tag, ".mem_addr"}, mem_addr, exp_addr);
    chk({tag, ".grant_d"}, grant_d, exp_d);
    chk({tag, ".busy"}, busy, 1'b1);
    if (exp_wr) chk({tag, ".mem_wdata"}, mem_wdata, exp_wd);
    for (int k = 0; k < lat; k++) begin
      if (toggle) begin
        if (exp_d) begin
          d_wdata = rand_line();
          d_addr  = rand_addr();
        end else begin
          i_addr = rand_addr();
        end
      end
      @(negedge clk);
      chk({tag, ".hold_addr"}, mem_addr, exp_addr);
      chk({tag, ".hold_rw"}, {mem_read, mem_write}, {!exp_wr, exp_wr});
      if (exp_wr) chk({tag, ".hold_wdata"}, mem_wdata, exp_wd);
    end
    mem_resp  = 1'b1;
    mem_rdata = rd;
    @(negedge clk);
    mem_resp  = 1'b0;
    mem_rdata = rand_line();
    if (exp_d) exp_d_rdata = rd;
    else       exp_i_rdata = rd;
    exp_grant_d = exp_d;
    chk({tag, ".resp"}, {i_resp, d_resp}, {!exp_d, exp_d});
    chk({tag, ".mem_idle"}, {mem_read, mem_write}, 2'b00);
    chk({tag, ".i_rdata"}, i_rdata, exp_i_rdata);
    chk({tag, ".d_rdata"}, d_rdata, exp_d_rdata);
    chk({tag, ".busy_done"}, busy, 1'b1);
    if (exp_d) begin
      d_read  = 1'b0;
      d_write = 1'b0;
    end else begin
      i_read = 1'b0;
    end
    @(negedge clk);
    chk({tag, ".resp_end"}, {i_resp, d_resp}, 2'b00);
    chk({tag, ".busy_idle"}, busy, 1'b0);
    chk({tag, ".grant_hold"}, grant_d, exp_grant_d);
    chk({tag, ".i_rdata_hold"}, i_rdata, exp_i_rdata);
    chk({tag, ".d_rdata_hold"}, d_rdata, exp_d_rdata);
  endtask

  // Predict the winner from the current request levels, then serve it
  task automatic grant_and_serve(input int lat, input cacheline_t rd, input bit toggle,
                                 input string tag, output bit took_d);
    bit          ip, dp, wr;
    logic [31:0] a;
    cacheline_t  wd;
    ip     = i_read;
    dp     = d_read || d_write;
    took_d = model_pick_d(ip, dp);
    wr     = took_d && d_write;
    a      = took_d ? d_addr : i_addr;
    wd     = d_wdata;
    model_grant(took_d, ip);
    serve(took_d, wr, a, wd, lat, rd, toggle, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         took;
    int         issued, served_d, nd_before_i;
    bit         seen_i;
    cacheline_t line_aa;
    cacheline_t junk;

    i_read = 0; i_addr = '0; d_read = 0; d_write = 0; d_addr = '0;
    d_wdata = '0; mem_rdata = '0; mem_resp = 0;
    line_aa = {32{8'hAA}};

    // Reset values while rst_n is low
    #1 rst_n = 1'b0;
    #1;
    chk("rst.busy", busy, 1'b0);
    chk("rst.grant_d", grant_d, 1'b0);
    chk("rst.mem_rw", {mem_read, mem_write}, 2'b00);
    chk("rst.mem_addr", mem_addr, '0);
    chk("rst.mem_wdata", mem_wdata, '0);
    chk("rst.resp", {i_resp, d_resp}, 2'b00);
    chk("rst.i_rdata", i_rdata, '0);
    chk("rst.d_rdata", d_rdata, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // I-only read, adaptor answers after 5 cycles
    i_read = 1; i_addr = 32'h0000_0040;
    grant_and_serve(5, line_aa, 0, "ionly", took);

    // Simultaneous I and D reads: D first, then I
    i_read = 1; i_addr = 32'h0000_0100;
    d_read = 1; d_addr = 32'h0000_0200;
    grant_and_serve(3, rand_line(), 0, "both.first", took);
    chk("both.first_is_d", took, 1'b1);
    grant_and_serve(2, rand_line(), 0, "both.second", took);
    chk("both.second_is_i", took, 1'b0);

    // D writeback with d_wdata/d_addr toggled during service
    d_write = 1; d_addr = 32'h0000_0080;
    d_wdata = {8{32'h1234_5678}};
    grant_and_serve(8, rand_line(), 1, "wb", took);

    // Starvation: I held while D issues 6 back-to-back requests
    i_read = 1; i_addr = 32'h0000_0300;
    issued = 0; served_d = 0; nd_before_i = 0; seen_i = 0;
    while ((served_d < 6 || i_read) && issued <= 6) begin
      if (issued < 6 && !d_read) begin
        issued++;
        d_read = 1; d_addr = 32'h0000_1000 + 32'(issued) * 32'h40;
      end
      grant_and_serve(1, rand_line(), 0, "starve", took);
      if (took) begin
        served_d++;
        if (!seen_i) nd_before_i++;
      end else begin
        seen_i = 1;
      end
    end
    chk("starve.d_before_i", 256'(nd_before_i), 256'(STARVE_LIMIT));
    chk("starve.i_served", seen_i, 1'b1);

    // Reset in the middle of a D transaction
    d_read = 1; d_addr = 32'h0000_0500;
    for (int k = 0; k < 3; k++) @(negedge clk);
    chk("rstmid.active", mem_read, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid.busy", busy, 1'b0);
    chk("rstmid.mem_rw", {mem_read, mem_write}, 2'b00);
    chk("rstmid.mem_addr", mem_addr, '0);
    chk("rstmid.grant_d", grant_d, 1'b0);
    chk("rstmid.rdata", {i_rdata, d_rdata}, '0);
    d_read = 0;
    streak = 0; exp_i_rdata = '0; exp_d_rdata = '0; exp_grant_d = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    i_read = 1; i_addr = 32'h0000_0600;
    grant_and_serve(2, rand_line(), 0, "rstmid.fresh", took);

    // Spurious mem_resp while IDLE
    junk = rand_line();
    mem_resp = 1; mem_rdata = junk;
    @(negedge clk);
    mem_resp = 0;
    chk("spur.resp", {i_resp, d_resp}, 2'b00);
    chk("spur.busy", busy, 1'b0);
    @(negedge clk);
    chk("spur.resp2", {i_resp, d_resp}, 2'b00);
    chk("spur.i_rdata", i_rdata, exp_i_rdata);
    chk("spur.d_rdata", d_rdata, exp_d_rdata);
    d_read = 1; d_addr = 32'h0000_0700;
    grant_and_serve(1, rand_line(), 0, "spur.after", took);

    // Randomized traffic: requests stay high until served
    for (int t = 0; t < 40; t++) begin
      if (!i_read && $urandom_range(0, 1) == 1) begin
        i_read = 1; i_addr = rand_addr();
      end
      if (!(d_read || d_write) && $urandom_range(0, 2) != 0) begin
        if ($urandom_range(0, 1) == 1) d_write = 1;
        else                           d_read  = 1;
        d_addr = rand_addr(); d_wdata = rand_line();
      end
      if (!i_read && !d_read && !d_write) begin
        i_read = 1; i_addr = rand_addr();
      end
      grant_and_serve(int'($urandom_range(0, 6)), rand_line(), bit'($urandom_range(0, 1)), "rnd", took);
    end
    for (int t = 0; t < 2; t++) begin
      if (i_read || d_read || d_write)
        grant_and_serve(int'($urandom_range(0, 3)), rand_line(), 0, "drain", took);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
